// File: rtl/geralds_interpolator.sv
// AXI-Stream frame upsampler: buffers one frame, then replays each sample RATIO times.
// Define INTERP_ZERO_STUFF_EN for zero-stuffed output instead of zero-order hold.
module geralds_interpolator #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_SIZE = 4,
    parameter int RATIO      = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  frame_err
);

    localparam int IW = $clog2(FRAME_SIZE);
    localparam int LW = $clog2(FRAME_SIZE + 1);
    localparam int RW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);
    localparam logic [RW-1:0] LAST_REP = RW'(RATIO - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic [LW-1:0]         len_q, len_d;
    logic [RW-1:0]         rep_q, rep_d;
    logic                  s_tready_q, s_tready_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  frame_err_q, frame_err_d;

    logic [DATA_WIDTH-1:0] mem_q [FRAME_SIZE];

    logic                  accept;
    logic                  out_fire;
    logic                  cur_last;
    logic                  hold_beat;
    logic [DATA_WIDTH-1:0] rd_data;

    assign accept   = (state_q == FILL) && s_tvalid && s_tready_q;
    assign out_fire = (state_q == DRAIN) && m_tready;
    assign cur_last = ((LW'(rd_idx_q) + LW'(1)) == len_q) && (rep_q == LAST_REP);

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        len_d       = len_q;
        rep_d       = rep_q;
        frame_err_d = 1'b0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (s_tlast || (wr_idx_q == LAST_IDX)) begin
                        // Error when the tlast and full-frame conditions disagree.
                        frame_err_d = s_tlast ^ (wr_idx_q == LAST_IDX);
                        len_d       = LW'(wr_idx_q) + LW'(1);
                        wr_idx_d    = '0;
                        rd_idx_d    = '0;
                        rep_d       = '0;
                        state_d     = DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (rep_q != LAST_REP) begin
                        rep_d = rep_q + RW'(1);
                    end else begin
                        rep_d = '0;
                        if (cur_last) begin
                            rd_idx_d = '0;
                            state_d  = FILL;
                        end else begin
                            rd_idx_d = rd_idx_q + IW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Output flops are loaded from next-state values; a length-1 frame needs the write bypass.
    always_comb begin
        rd_data = mem_q[rd_idx_d];
        if (accept && (wr_idx_q == rd_idx_d)) begin
            rd_data = s_tdata;
        end
`ifdef INTERP_ZERO_STUFF_EN
        hold_beat = (rep_d == '0);
`else
        hold_beat = 1'b1;
`endif
        s_tready_d = (state_d == FILL);
        m_tvalid_d = (state_d == DRAIN);
        m_tlast_d  = (state_d == DRAIN)
                     && ((LW'(rd_idx_d) + LW'(1)) == len_d)
                     && (rep_d == LAST_REP);
        m_tdata_d  = '0;
        if ((state_d == DRAIN) && hold_beat) begin
            m_tdata_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            len_q       <= len_d;
            rep_q       <= rep_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tdata_q   <= m_tdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_idx_q] <= s_tdata;
        end
    end

    assign s_tready  = s_tready_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign m_tdata   = m_tdata_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/geralds_interpolator.md
Name: geralds_interpolator

Overview:
- AXI-Stream upsampler; the inverse of the team's decimator. Consumes framed, decimated sample streams and rebuilds a stream at the higher clock-rate cadence.
- Buffers one frame of FRAME_SIZE samples. Then emits each sample RATIO times, either as a zero-order hold or zero-stuffed.
- Sits between an FFT/processing result stream and a DAC-side or test consumer.

Parameters:
- DATA_WIDTH, 32, sample width in bits.
- FRAME_SIZE, 4, samples per input frame; must be >= 2.
- RATIO, 15, output beats per input sample; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- s_tdata  in  DATA_WIDTH  input sample.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  input end of frame.
- m_tdata  out  DATA_WIDTH  output sample.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  last beat of the upsampled frame.
- frame_err  out  1  one-cycle pulse on an input framing error.

Behaviour:
- Internal state:
  - buffer mem[FRAME_SIZE].
  - wr_idx and rd_idx, each $clog2(FRAME_SIZE) bits.
  - len register (frame length, 1..FRAME_SIZE).
  - rep counter, max($clog2(RATIO),1) bits.
  - FSM with states FILL and DRAIN.
- Reset (reset==0 at posedge clk):
  - state=FILL; wr_idx=rd_idx=rep=0; len=0.
  - s_tready=0 during the reset cycle and 1 from the first cycle after reset deasserts.
  - m_tvalid=0, m_tlast=0, frame_err=0, m_tdata=0.
- Reset mid-operation discards the partial frame; no output beat may follow reset until a new frame is filled.
- FILL:
  - s_tready=1, m_tvalid=0.
  - On each s_tvalid&&s_tready: mem[wr_idx]<=s_tdata and wr_idx++.
  - Frame ends on the accepted beat when s_tlast==1 or wr_idx==FRAME_SIZE-1. At that point: len<=wr_idx+1, wr_idx<=0, rd_idx<=0, rep<=0, state<=DRAIN.
  - Ending on s_tlast with wr_idx<FRAME_SIZE-1 (early tlast) is a truncated frame: frame_err pulses the next cycle, and only len samples are drained.
  - Ending on wr_idx==FRAME_SIZE-1 with s_tlast==0 (missing tlast) closes the frame anyway and frame_err pulses. The following input beats begin a new frame.
- DRAIN:
  - s_tready=0, m_tvalid=1.
  - m_tdata=mem[rd_idx] (combinational read, registered index).
  - m_tlast=1 iff rd_idx==len-1 and rep==RATIO-1.
  - On m_tvalid&&m_tready:
    - If rep<RATIO-1: rep++.
    - Else: rep<=0 and rd_idx++.
    - On the m_tlast beat: state<=FILL, and s_tready rises the next cycle.
  - m_tdata, m_tvalid and m_tlast stay stable while m_tready==0 (AXI-Stream rule).
- Latency:
  - The first output beat is valid one cycle after the final input beat is accepted.
  - Fill and drain do not overlap, so throughput = 1 frame per (len + len*RATIO) cycles at m_tready==1.
- RATIO==1: each sample is emitted once, and m_tlast is on the last sample.
- No arithmetic on data; the counters wrap only via explicit compare-and-clear, never natural overflow.

Optional Feature:
- Macro INTERP_ZERO_STUFF_EN.
  - Defined: within each sample's group of RATIO beats, the beat with rep==0 carries mem[rd_idx] and beats with rep!=0 carry all zeros. m_tlast timing is unchanged.
  - Undefined: zero-order hold, with all RATIO beats carrying mem[rd_idx].

Test Plan (DATA_WIDTH=32, FRAME_SIZE=4, RATIO=3):
- Basic hold: frame 10,11,12,13 with tlast on 13, m_tready=1 -> 12 beats 10,10,10,11,11,11,12,12,12,13,13,13. m_tlast only on beat 12, frame_err never pulses, s_tready=0 throughout the drain.
- Backpressure: same frame with m_tready toggling 1,0,0,1,... -> identical 12-beat sequence. Data, valid and last stay stable on stalled cycles, and no beat is duplicated or dropped.
- Early tlast: 20,21 with tlast on 21 -> frame_err pulses once. Output is 20,20,20,21,21,21 with m_tlast on beat 6, then s_tready=1.
- Missing tlast: 30,31,32,33,34,35,36,37 with tlast only on 37 -> frame_err pulses for the first frame. Output 30..33 each ×3 with m_tlast on beat 12, then 34..37 each ×3 with m_tlast, and no error on the second frame.
- Reset mid-drain: reset=0 for 1 cycle at beat 5 of the basic frame -> m_tvalid=0 the next cycle and s_tready=1 after reset releases. The next frame 40..43 outputs cleanly from 40.
- INTERP_ZERO_STUFF_EN defined, basic frame -> 10,0,0,11,0,0,12,0,0,13,0,0 with m_tlast on beat 12.
